spi_apb_burst_bridge: RTL and testbench
=======================================

Name: spi_apb_burst_bridge

Overview:
- Parametrised successor to the SPI command decoder. Decodes SPI frames from the SPI slave front-end and issues APB master transfers.
- Generalised in address/data width and error address map.
- New over the previous generation: registered APB outputs, burst read/write with address auto-increment, SLVERR capture, overrun detection, sticky error status vector.
- Sits between spi_slave_common and the chip APB register fabric, clocked by the SPI clock.

Parameters:
- ADDR_W, 10, APB address width (byte address).
- DATA_W, 32, APB data width; multiple of 8.
- BURST_W, 4, burst length field width; max burst = 2^BURST_W words.
- ERR_ADDR0, 10'h004, APB address for CRC error payload log.
- ERR_ADDR1, 10'h008, APB address for CRC error cmd/crc log.
- CHIP_ID, 32'h01010164, value returned by the CHIP_ID command.
- TIMEOUT_CYC, 64, APB access timeout in cycles; only used with APB_TIMEOUT_EN.

Ports:
- spi_clk_i  in  1  clock
- spi_cs_i  in  1  reset, synchronous active-high (chip-select deasserted)
- spi_rx_word_i  in  DATA_W+4  rx frame: [DATA_W+3:DATA_W] cmd, [DATA_W-1:0] payload
- rx_done_i  in  1  1-cycle pulse, rx frame valid
- crc5_chk_i  in  1  CRC ok for the current frame
- crc5_ext_i  in  5  received CRC5
- spi_cmd4b_i  in  4  short command
- spi_cmd4b_en_i  in  1  short command valid pulse
- tx_done_i  in  1  tx word shifted out
- spi_tx_word_o  out  DATA_W  tx word
- tx_ready_o  out  1  tx word valid
- stim_mask_en_i  in  8  stimulator status
- apb_addr_o  out  ADDR_W  APB address
- apb_sel_o  out  1  APB PSEL
- apb_enable_o  out  1  APB PENABLE
- apb_write_o  out  1  APB PWRITE
- apb_wdata_o  out  DATA_W  APB PWDATA
- apb_strb_o  out  DATA_W/8  APB PSTRB, constant all ones
- apb_rdata_i  in  DATA_W  APB PRDATA
- apb_ready_i  in  1  APB PREADY
- apb_slverr_i  in  1  APB PSLVERR
- chip_id_o  out  32  constant CHIP_ID
- err_status_o  out  4  sticky: [0] crc, [1] slverr, [2] timeout, [3] overrun/illegal
- error_o  out  1  OR of err_status_o, registered

Behaviour:
- Reset (spi_cs_i high at clock edge): FSMs go to S_IDLE/APB_IDLE. All APB outputs 0 except strb. apb_wdata_o, spi_tx_word_o, tx_ready_o, err_status_o, error_o, burst counter and address all 0. Reset mid-transfer drops PSEL the next edge, with no completion.
- Commands: 1 WR_ADD, 2 WR_DATA, 3 RD_ADD, 4 RD_DATA, 5 CONFIG, 6 CHIP_ID (4b), 7 STIM_ST (4b), 8 BURST_WR, 9 BURST_RD.
  - BURST_WR and BURST_RD payload: [ADDR_W-1:0] start address, [ADDR_W+BURST_W-1:ADDR_W] length-1.
- Main FSM states:
  - S_IDLE
  - S_WR_PEND
  - S_RD_PEND
  - S_TX_WAIT
  - S_BURST_WR (awaiting data words)
  - S_ERR1, S_ERR2
- Transitions from S_IDLE on rx_done_i with crc ok:
  - WR_DATA: latch payload into apb_wdata_o; stay in S_IDLE.
  - WR_ADD: addr = payload → S_WR_PEND.
  - RD_ADD: addr = payload → S_RD_PEND.
  - CONFIG: clear wdata, tx word, tx_ready, err_status, burst state; stay in S_IDLE.
  - BURST_WR: load addr/count → S_BURST_WR.
  - BURST_RD: load addr/count → S_RD_PEND.
- CRC fail on commands 1/2/3/8/9 → S_ERR1: APB write of payload to ERR_ADDR0.
  - Then S_ERR2: APB write of {zeros, crc5_ext_i, cmd} to ERR_ADDR1.
  - Then S_IDLE, with err_status[0] set.
- RD_DATA in S_IDLE, or cmd >9: err_status[3] set, no transfer.
- Short commands in S_IDLE: spi_cmd4b_en_i with 6 or 7 loads spi_tx_word_o (CHIP_ID, or {zeros, stim_mask_en_i}), sets tx_ready_o → S_TX_WAIT.
  - If it coincides with rx_done_i, the short command wins and the frame is dropped.
- S_BURST_WR: each valid WR_DATA frame latches wdata → S_WR_PEND.
  - Write completion returns to S_BURST_WR while the count is nonzero, else S_IDLE.
  - Any other command aborts the burst, sets err_status[3], returns to S_IDLE.
- S_RD_PEND completion: spi_tx_word_o <= apb_rdata_i, tx_ready_o <= 1 → S_TX_WAIT.
- S_TX_WAIT: rx_done_i with RD_DATA is expected (no action).
  - On tx_done_i: clear tx_ready_o and tx word. If burst read count is nonzero → S_RD_PEND, else S_IDLE.
- rx_done_i in S_WR_PEND, S_RD_PEND or S_ERRx, or a non-RD_DATA frame in S_TX_WAIT: frame dropped, err_status[3] set.
- After each burst beat: addr += DATA_W/8, wrapping modulo 2^ADDR_W; count -= 1.
- APB FSM: APB_IDLE → SETUP (sel=1, enable=0) → ACCESS (sel=1, enable=1), held until apb_ready_i.
  - All outputs are registered. A request accepted at edge N gives SETUP visible after N+1 and ACCESS after N+2. Completion takes effect on the edge where ACCESS and ready are both high.
  - addr/wdata/write are stable from SETUP through ACCESS.
- SLVERR at completion: err_status[1] set. Read data is still returned. Burst continues.
- error_o = registered OR of err_status_o; sticky until reset or CONFIG.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: a counter runs in ACCESS. When it reaches TIMEOUT_CYC without ready:
  - PSEL/PENABLE drop the next edge and err_status[2] is set.
  - Main FSM goes to S_IDLE and any burst is cancelled; tx_ready_o stays 0.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- WR_DATA payload 0xDEADBEEF then WR_ADD 0x010 → one APB write, addr 0x010, wdata 0xDEADBEEF, PWRITE=1; SETUP 1 cycle, error_o=0.
- BURST_RD addr 0x100 len-1=2, slave returns 0x11/0x22/0x33 with 2 wait states each → three reads at 0x100/0x104/0x108; tx_ready_o rises after each; tx_done clears it.
- WR_ADD with crc5_chk_i=0, crc5_ext 0x1A, payload 0x12345678 → writes 0x12345678@0x004, then 0x1A1@0x008; err_status=4'b0001, error_o=1.
- spi_cmd4b 6 coincident with rx_done WR_DATA → tx word 0x01010164, frame dropped; RD_DATA then tx_done → back to idle.
- BURST_WR len-1=1 at 0x3FC with PSLVERR on the first beat → writes 0x3FC then 0x000 (wrap); err_status[1]=1; CONFIG clears it.
- APB_TIMEOUT_EN, TIMEOUT_CYC=8, PREADY held 0 on RD_ADD → PSEL drops after 8 ACCESS cycles, err_status[2]=1, tx_ready_o stays 0.

Source files
------------

// File: rtl/spi_apb_burst_bridge.sv
// spi_apb_burst_bridge: decodes SPI command frames and issues APB master
// transfers, with burst read/write (address auto-increment), CRC error
// logging to two APB addresses, SLVERR capture and sticky error status.
// Optional feature macro: APB_TIMEOUT_EN (ACCESS-phase timeout, TIMEOUT_CYC).
module spi_apb_burst_bridge #(
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 32,
  parameter int                BURST_W     = 4,
  parameter logic [ADDR_W-1:0] ERR_ADDR0   = 10'h004,
  parameter logic [ADDR_W-1:0] ERR_ADDR1   = 10'h008,
  parameter logic [31:0]       CHIP_ID     = 32'h01010164,
  parameter int                TIMEOUT_CYC = 64
) (
  input  logic                spi_clk_i,
  input  logic                spi_cs_i,
  input  logic [DATA_W+3:0]   spi_rx_word_i,
  input  logic                rx_done_i,
  input  logic                crc5_chk_i,
  input  logic [4:0]          crc5_ext_i,
  input  logic [3:0]          spi_cmd4b_i,
  input  logic                spi_cmd4b_en_i,
  input  logic                tx_done_i,
  output logic [DATA_W-1:0]   spi_tx_word_o,
  output logic                tx_ready_o,
  input  logic [7:0]          stim_mask_en_i,
  output logic [ADDR_W-1:0]   apb_addr_o,
  output logic                apb_sel_o,
  output logic                apb_enable_o,
  output logic                apb_write_o,
  output logic [DATA_W-1:0]   apb_wdata_o,
  output logic [DATA_W/8-1:0] apb_strb_o,
  input  logic [DATA_W-1:0]   apb_rdata_i,
  input  logic                apb_ready_i,
  input  logic                apb_slverr_i,
  output logic [31:0]         chip_id_o,
  output logic [3:0]          err_status_o,
  output logic                error_o
);

  localparam logic [3:0] CMD_WR_ADD   = 4'd1;
  localparam logic [3:0] CMD_WR_DATA  = 4'd2;
  localparam logic [3:0] CMD_RD_ADD   = 4'd3;
  localparam logic [3:0] CMD_RD_DATA  = 4'd4;
  localparam logic [3:0] CMD_CONFIG   = 4'd5;
  localparam logic [3:0] CMD_CHIP_ID  = 4'd6;
  localparam logic [3:0] CMD_STIM_ST  = 4'd7;
  localparam logic [3:0] CMD_BURST_WR = 4'd8;
  localparam logic [3:0] CMD_BURST_RD = 4'd9;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_PEND, S_RD_PEND, S_TX_WAIT, S_BURST_WR, S_ERR1, S_ERR2
  } state_e;

  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_e;

  state_e              state_q, state_d;
  apb_e                apb_q, apb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                sel_q, sel_d;
  logic                en_q, en_d;
  logic [DATA_W-1:0]   tx_word_q, tx_word_d;
  logic                tx_ready_q, tx_ready_d;
  logic [3:0]          err_q, err_d;
  logic                error_q, error_d;
  logic [BURST_W-1:0]  cnt_q, cnt_d;
  logic                burst_q, burst_d;
  logic [8:0]          err_info_q, err_info_d;

  logic [3:0]          cmd;
  logic [DATA_W-1:0]   payload;
  logic                apb_done;
  logic                tmo_hit;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign cmd     = spi_rx_word_i[DATA_W+3:DATA_W];
  assign payload = spi_rx_word_i[DATA_W-1:0];

  // Next-state logic for the command FSM, the APB FSM and all datapath registers.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block infers a latch.
    state_d    = state_q;
    apb_d      = apb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    tx_word_d  = tx_word_q;
    tx_ready_d = tx_ready_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    burst_d    = burst_q;
    err_info_d = err_info_q;
    error_d    = |err_q;

    apb_done = (apb_q == APB_ACCESS) && apb_ready_i;
    tmo_hit  = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_d   = (apb_q == APB_ACCESS) ? tmo_q + 1'b1 : '0;
    tmo_hit = (apb_q == APB_ACCESS) && !apb_ready_i && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`endif

    // APB sequencing: a pending main state requests exactly one transfer.
    unique case (apb_q)
      APB_IDLE:   if (state_q inside {S_WR_PEND, S_RD_PEND, S_ERR1, S_ERR2}) apb_d = APB_SETUP;
      APB_SETUP:  apb_d = APB_ACCESS;
      APB_ACCESS: if (apb_ready_i || tmo_hit) apb_d = APB_IDLE;
      default:    apb_d = APB_IDLE;
    endcase

    if (apb_done && apb_slverr_i) err_d[1] = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        // Short command wins over a coincident frame.
        if (spi_cmd4b_en_i && (spi_cmd4b_i == CMD_CHIP_ID || spi_cmd4b_i == CMD_STIM_ST)) begin
          tx_word_d  = (spi_cmd4b_i == CMD_CHIP_ID) ? DATA_W'(CHIP_ID) : DATA_W'(stim_mask_en_i);
          tx_ready_d = 1'b1;
          state_d    = S_TX_WAIT;
        end else if (rx_done_i) begin
          if (cmd == CMD_RD_DATA || cmd > CMD_BURST_RD) begin
            err_d[3] = 1'b1;
          end else if (crc5_chk_i) begin
            unique case (cmd)
              CMD_WR_DATA: wdata_d = payload;
              CMD_WR_ADD: begin
                addr_d = payload[ADDR_W-1:0]; write_d = 1'b1;
                burst_d = 1'b0; cnt_d = '0; state_d = S_WR_PEND;
              end
              CMD_RD_ADD: begin
                addr_d = payload[ADDR_W-1:0]; write_d = 1'b0;
                burst_d = 1'b0; cnt_d = '0; state_d = S_RD_PEND;
              end
              CMD_CONFIG: begin
                wdata_d = '0; tx_word_d = '0; tx_ready_d = 1'b0; err_d = '0;
                burst_d = 1'b0; cnt_d = '0; addr_d = '0;
              end
              CMD_BURST_WR, CMD_BURST_RD: begin
                addr_d  = payload[ADDR_W-1:0];
                cnt_d   = payload[ADDR_W+BURST_W-1:ADDR_W];
                burst_d = 1'b1;
                write_d = (cmd == CMD_BURST_WR);
                state_d = (cmd == CMD_BURST_WR) ? S_BURST_WR : S_RD_PEND;
              end
              default: ;
            endcase
          end else if (cmd inside {CMD_WR_ADD, CMD_WR_DATA, CMD_RD_ADD, CMD_BURST_WR, CMD_BURST_RD}) begin
            addr_d     = ERR_ADDR0;
            wdata_d    = payload;
            write_d    = 1'b1;
            err_info_d = {crc5_ext_i, cmd};
            state_d    = S_ERR1;
          end
        end
      end
      S_BURST_WR: begin
        if (rx_done_i) begin
          if (cmd == CMD_WR_DATA && crc5_chk_i) begin
            wdata_d = payload;
            state_d = S_WR_PEND;
          end else begin
            err_d[3] = 1'b1; burst_d = 1'b0; cnt_d = '0; state_d = S_IDLE;
          end
        end
      end
      S_TX_WAIT: begin
        if (rx_done_i && cmd != CMD_RD_DATA) err_d[3] = 1'b1;
        if (tx_done_i) begin
          tx_ready_d = 1'b0;
          tx_word_d  = '0;
          if (burst_q && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1; addr_d = addr_q + STEP; state_d = S_RD_PEND;
          end else begin
            burst_d = 1'b0; state_d = S_IDLE;
          end
        end
      end
      default: begin // S_WR_PEND, S_RD_PEND, S_ERR1, S_ERR2
        if (rx_done_i) err_d[3] = 1'b1;
        if (apb_done) begin
          unique case (state_q)
            S_WR_PEND:
              if (burst_q && cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1; addr_d = addr_q + STEP; state_d = S_BURST_WR;
              end else begin
                burst_d = 1'b0; state_d = S_IDLE;
              end
            S_RD_PEND: begin
              tx_word_d = apb_rdata_i; tx_ready_d = 1'b1; state_d = S_TX_WAIT;
            end
            S_ERR1: begin
              addr_d  = ERR_ADDR1;
              wdata_d = {{(DATA_W-9){1'b0}}, err_info_q};
              state_d = S_ERR2;
            end
            S_ERR2: begin
              err_d[0] = 1'b1; state_d = S_IDLE;
            end
            default: ;
          endcase
        end else if (tmo_hit) begin
          err_d[2] = 1'b1; burst_d = 1'b0; cnt_d = '0; state_d = S_IDLE;
        end
      end
    endcase

    sel_d = (apb_d != APB_IDLE);
    en_d  = (apb_d == APB_ACCESS);
  end

  // State and output registers; chip-select high is a synchronous reset.
  always_ff @(posedge spi_clk_i) begin
    if (spi_cs_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
      state_q    <= S_IDLE;
      apb_q      <= APB_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      sel_q      <= 1'b0;
      en_q       <= 1'b0;
      tx_word_q  <= '0;
      tx_ready_q <= 1'b0;
      err_q      <= '0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
      burst_q    <= 1'b0;
      err_info_q <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      apb_q      <= apb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      tx_word_q  <= tx_word_d;
      tx_ready_q <= tx_ready_d;
      err_q      <= err_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
      burst_q    <= burst_d;
      err_info_q <= err_info_d;
`ifdef APB_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign apb_addr_o    = addr_q;
  assign apb_sel_o     = sel_q;
  assign apb_enable_o  = en_q;
  assign apb_write_o   = write_q;
  assign apb_wdata_o   = wdata_q;
  assign apb_strb_o    = '1;
  assign spi_tx_word_o = tx_word_q;
  assign tx_ready_o    = tx_ready_q;
  assign chip_id_o     = CHIP_ID;
  assign err_status_o  = err_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_spi_apb_burst_bridge.sv
// Directed bench for spi_apb_burst_bridge: expected APB transfers and tx
// words go into scoreboards as stimulus is issued; an APB slave model pops
// and compares transfers, the main sequence pops and compares tx words.
module tb_spi_apb_burst_bridge;

  logic        spi_clk_i = 1'b0;
  logic        spi_cs_i = 1'b1;
  logic [35:0] spi_rx_word_i = '0;
  logic        rx_done_i = 1'b0;
  logic        crc5_chk_i = 1'b1;
  logic [4:0]  crc5_ext_i = '0;
  logic [3:0]  spi_cmd4b_i = '0;
  logic        spi_cmd4b_en_i = 1'b0;
  logic        tx_done_i = 1'b0;
  logic [31:0] spi_tx_word_o;
  logic        tx_ready_o;
  logic [7:0]  stim_mask_en_i = 8'hA5;
  logic [9:0]  apb_addr_o;
  logic        apb_sel_o, apb_enable_o, apb_write_o;
  logic [31:0] apb_wdata_o;
  logic [3:0]  apb_strb_o;
  logic [31:0] apb_rdata_i = '0;
  logic        apb_ready_i = 1'b0;
  logic        apb_slverr_i = 1'b0;
  logic [31:0] chip_id_o;
  logic [3:0]  err_status_o;
  logic        error_o;

  spi_apb_burst_bridge dut (
    .spi_clk_i(spi_clk_i), .spi_cs_i(spi_cs_i), .spi_rx_word_i(spi_rx_word_i),
    .rx_done_i(rx_done_i), .crc5_chk_i(crc5_chk_i), .crc5_ext_i(crc5_ext_i),
    .spi_cmd4b_i(spi_cmd4b_i), .spi_cmd4b_en_i(spi_cmd4b_en_i), .tx_done_i(tx_done_i),
    .spi_tx_word_o(spi_tx_word_o), .tx_ready_o(tx_ready_o), .stim_mask_en_i(stim_mask_en_i),
    .apb_addr_o(apb_addr_o), .apb_sel_o(apb_sel_o), .apb_enable_o(apb_enable_o),
    .apb_write_o(apb_write_o), .apb_wdata_o(apb_wdata_o), .apb_strb_o(apb_strb_o),
    .apb_rdata_i(apb_rdata_i), .apb_ready_i(apb_ready_i), .apb_slverr_i(apb_slverr_i),
    .chip_id_o(chip_id_o), .err_status_o(err_status_o), .error_o(error_o)
  );

  always #5 spi_clk_i = ~spi_clk_i;

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        slverr;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] tx_q[$];
  int          compared = 0;
  int          mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge spi_clk_i);
    #1;
  endtask

  task automatic push_xfer(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                           input int w, input logic [31:0] rd, input logic se);
    xfer_t x;
    x.wr = wr; x.addr = a; x.wdata = wd; x.waits = w; x.rdata = rd; x.slverr = se;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input logic [3:0] c, input logic [31:0] pl,
                            input logic ok = 1'b1, input logic [4:0] crc = 5'h0);
    spi_rx_word_i = {c, pl}; rx_done_i = 1'b1; crc5_chk_i = ok; crc5_ext_i = crc;
    tick();
    rx_done_i = 1'b0; crc5_chk_i = 1'b1;
  endtask

  task automatic pulse_tx_done();
    tx_done_i = 1'b1;
    tick();
    tx_done_i = 1'b0;
  endtask

  // Wait until at most n transfers remain outstanding and the bus is idle.
  task automatic wait_q(input int n);
    int k = 0;
    while (!(exp_q.size() <= n && !apb_sel_o) && k < 400) begin tick(); k++; end
    check("apb_idle_bound", 32'(k < 400), 32'd1);
    tick(); tick();
  endtask

  task automatic wait_tx();
    int k = 0;
    logic [31:0] e;
    while (!tx_ready_o && k < 400) begin tick(); k++; end
    check("tx_ready_bound", 32'(tx_ready_o), 32'd1);
    e = (tx_q.size() != 0) ? tx_q.pop_front() : 32'hBAD0BAD0;
    check("tx_word", spi_tx_word_o, e);
  endtask

  // APB slave model and transfer scoreboard, evaluated on the falling edge.
  initial begin
    xfer_t cur;
    int    wcnt = 0;
    int    setup_cnt = 0;
    bit    in_access = 1'b0;
    cur = '{wr: 1'b0, addr: '0, wdata: '0, waits: 0, rdata: '0, slverr: 1'b0};
    forever begin
      @(negedge spi_clk_i);
      if (spi_cs_i || !apb_sel_o) begin
        apb_ready_i = 1'b0; apb_slverr_i = 1'b0; in_access = 1'b0; setup_cnt = 0;
      end else if (!apb_enable_o) begin
        setup_cnt++;
      end else begin
        if (!in_access) begin
          in_access = 1'b1; wcnt = 0;
          check("setup_cycles", 32'(setup_cnt), 32'd1);
          check("unexpected_xfer", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          check("apb_addr", 32'(apb_addr_o), 32'(cur.addr));
          check("apb_write", 32'(apb_write_o), 32'(cur.wr));
          if (cur.wr) check("apb_wdata", apb_wdata_o, cur.wdata);
        end
        if (wcnt >= cur.waits) begin
          apb_ready_i = 1'b1; apb_rdata_i = cur.rdata; apb_slverr_i = cur.slverr;
        end else begin
          apb_ready_i = 1'b0; wcnt++;
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick(); tick();
    check("rst_sel", 32'(apb_sel_o), 32'd0);
    check("rst_enable", 32'(apb_enable_o), 32'd0);
    check("rst_write", 32'(apb_write_o), 32'd0);
    check("rst_addr", 32'(apb_addr_o), 32'd0);
    check("rst_wdata", apb_wdata_o, 32'd0);
    check("rst_tx_word", spi_tx_word_o, 32'd0);
    check("rst_tx_ready", 32'(tx_ready_o), 32'd0);
    check("rst_err", 32'(err_status_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("strb", 32'(apb_strb_o), 32'hF);
    check("chip_id", chip_id_o, 32'h01010164);
    spi_cs_i = 1'b0;
    tick();

    // Single write
    send_frame(4'd2, 32'hDEADBEEF);
    push_xfer(1'b1, 10'h010, 32'hDEADBEEF, 0, '0, 1'b0);
    send_frame(4'd1, 32'h010);
    wait_q(0);
    check("wr_err", 32'(err_status_o), 32'd0);
    check("wr_error_o", 32'(error_o), 32'd0);

    // Burst read of three words, two wait states each
    push_xfer(1'b0, 10'h100, '0, 2, 32'h11, 1'b0); tx_q.push_back(32'h11);
    push_xfer(1'b0, 10'h104, '0, 2, 32'h22, 1'b0); tx_q.push_back(32'h22);
    push_xfer(1'b0, 10'h108, '0, 2, 32'h33, 1'b0); tx_q.push_back(32'h33);
    send_frame(4'd9, 32'h0000_0900);
    for (int i = 0; i < 3; i++) begin
      wait_tx();
      send_frame(4'd4, 32'h0);
      pulse_tx_done();
      check("brd_tx_ready_clr", 32'(tx_ready_o), 32'd0);
    end
    wait_q(0);
    check("brd_err", 32'(err_status_o), 32'd0);

    // CRC failure on WR_ADD logs two error writes
    push_xfer(1'b1, 10'h004, 32'h12345678, 0, '0, 1'b0);
    push_xfer(1'b1, 10'h008, 32'h000001A1, 1, '0, 1'b0);
    send_frame(4'd1, 32'h12345678, 1'b0, 5'h1A);
    wait_q(0);
    check("crc_err", 32'(err_status_o), 32'h1);
    check("crc_error_o", 32'(error_o), 32'd1);
    send_frame(4'd5, 32'h0);
    tick();
    check("cfg_err", 32'(err_status_o), 32'h0);
    check("cfg_error_o", 32'(error_o), 32'd0);

    // Short command coincident with a frame: short command wins
    tx_q.push_back(32'h01010164);
    spi_cmd4b_i = 4'd6; spi_cmd4b_en_i = 1'b1;
    send_frame(4'd2, 32'hCAFEF00D);
    spi_cmd4b_en_i = 1'b0;
    wait_tx();
    check("dropped_frame_wdata", apb_wdata_o, 32'h0);
    send_frame(4'd4, 32'h0);
    pulse_tx_done();
    check("chip_tx_ready_clr", 32'(tx_ready_o), 32'd0);
    check("chip_tx_word_clr", spi_tx_word_o, 32'd0);
    check("chip_err", 32'(err_status_o), 32'h0);
    tx_q.push_back(32'h000000A5);
    spi_cmd4b_i = 4'd7; spi_cmd4b_en_i = 1'b1;
    tick();
    spi_cmd4b_en_i = 1'b0;
    wait_tx();
    pulse_tx_done();

    // Burst write wrapping past the top of the address map, SLVERR on beat 0
    push_xfer(1'b1, 10'h3FC, 32'hAAAA0001, 1, '0, 1'b1);
    push_xfer(1'b1, 10'h000, 32'hBBBB0002, 0, '0, 1'b0);
    send_frame(4'd8, 32'h0000_07FC);
    send_frame(4'd2, 32'hAAAA0001);
    wait_q(1);
    send_frame(4'd2, 32'hBBBB0002);
    wait_q(0);
    check("bwr_slverr", 32'(err_status_o), 32'h2);
    send_frame(4'd5, 32'h0);
    check("bwr_cfg", 32'(err_status_o), 32'h0);

    // Frame during a pending write is dropped and flagged
    send_frame(4'd2, 32'h55);
    push_xfer(1'b1, 10'h020, 32'h55, 4, '0, 1'b0);
    send_frame(4'd1, 32'h020);
    send_frame(4'd2, 32'h66);
    wait_q(0);
    check("pend_drop_err", 32'(err_status_o), 32'h8);
    check("pend_drop_wdata", apb_wdata_o, 32'h55);
    send_frame(4'd5, 32'h0);

    // Illegal commands in idle
    send_frame(4'd4, 32'h0);
    tick();
    check("rd_data_idle", 32'(err_status_o), 32'h8);
    send_frame(4'd5, 32'h0);
    send_frame(4'hC, 32'h0);
    tick();
    check("cmd_gt9", 32'(err_status_o), 32'h8);
    check("cmd_gt9_sel", 32'(apb_sel_o), 32'd0);
    send_frame(4'd5, 32'h0);

    // Long wait states on a read: timeout when enabled, indefinite wait otherwise
    push_xfer(1'b0, 10'h040, '0, 80, 32'h77, 1'b0);
    send_frame(4'd3, 32'h040);
    for (int i = 0; i < 75; i++) tick();
`ifdef APB_TIMEOUT_EN
    check("tmo_sel", 32'(apb_sel_o), 32'd0);
    check("tmo_err", 32'(err_status_o), 32'h4);
    check("tmo_tx_ready", 32'(tx_ready_o), 32'd0);
`else
    check("no_tmo_sel", 32'(apb_sel_o), 32'd1);
    tx_q.push_back(32'h77);
    wait_tx();
    pulse_tx_done();
    wait_q(0);
    check("no_tmo_err", 32'(err_status_o), 32'h0);
`endif
    send_frame(4'd5, 32'h0);

    // Reset in the middle of an ACCESS phase
    push_xfer(1'b0, 10'h030, '0, 20, 32'h99, 1'b0);
    send_frame(4'd3, 32'h030);
    for (int i = 0; i < 4; i++) tick();
    check("mid_rst_in_access", 32'(apb_enable_o), 32'd1);
    spi_cs_i = 1'b1;
    tick();
    spi_cs_i = 1'b0;
    check("mid_rst_sel", 32'(apb_sel_o), 32'd0);
    check("mid_rst_enable", 32'(apb_enable_o), 32'd0);
    tick(); tick();
    check("mid_rst_tx_ready", 32'(tx_ready_o), 32'd0);
    check("leftover_xfers", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
